// File: rtl/stream_mux_if.sv
// Handshake bundle between N producer streams and one consumer around stream_mux.
// The slave modport is the mux's view; the master modport is the surrounding system's view.
interface stream_mux_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH*WIDTH-1:0] data_i;
    logic [NUM_CH-1:0]       valid_i;
    logic [NUM_CH-1:0]       ready_o;
    logic [SEL_W-1:0]        sel_i;
    logic [WIDTH-1:0]        data_o;
    logic                    valid_o;
    logic                    ready_i;
    logic [SEL_W-1:0]        grant_o;

    modport slave (
        input  data_i, valid_i, sel_i, ready_i,
        output ready_o, data_o, valid_o, grant_o
    );

    modport master (
        output data_i, valid_i, sel_i, ready_i,
        input  ready_o, data_o, valid_o, grant_o
    );
endinterface

// File: rtl/stream_mux.sv
// N:1 valid/ready stream multiplexer with a single registered output stage.
// MODE=0 takes the channel from sel_i; MODE=1 arbitrates round-robin over valid_i.
module stream_mux #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int MODE   = 0
) (
    input logic         clk,
    input logic         reset_n,
    stream_mux_if.slave bus
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                load_en;
    logic                has_pick;
    logic [SEL_W-1:0]    pick;
    logic [SEL_W-1:0]    last_grant;
    logic [WIDTH-1:0]    ch_data [NUM_CH];

    // The output register can take a word when empty or draining this cycle.
    // Gated by reset_n so no channel sees ready_o while reset is held.
    assign load_en = reset_n && (!bus.valid_o || bus.ready_i);

    // Unpack the flat channel bus and drive the one-hot ready per channel.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_data[k]     = bus.data_i[k*WIDTH +: WIDTH];
        assign bus.ready_o[k] = load_en && has_pick && (pick == SEL_W'(k));
    end

    // Choose the candidate channel; has_pick implies that channel is valid.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_s;
        pick     = '0;
        has_pick = 1'b0;
        idx      = 0;
        idx_s    = '0;
        if (MODE == 0) begin
            // Out-of-range selects (non power-of-two NUM_CH) choose nothing.
            if (int'(bus.sel_i) < NUM_CH) begin
                pick     = bus.sel_i;
                has_pick = bus.valid_i[bus.sel_i];
            end
        end else begin
            // Search starts just after the last granted channel and wraps.
            for (int i = 1; i <= NUM_CH; i++) begin
                idx   = (int'(last_grant) + i) % NUM_CH;
                idx_s = SEL_W'(idx);
                if (!has_pick && bus.valid_i[idx_s]) begin
                    has_pick = 1'b1;
                    pick     = idx_s;
                end
            end
        end
    end

    // Output register and arbitration pointer; pointer moves only on a handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.valid_o <= 1'b0;
            bus.data_o  <= '0;
            bus.grant_o <= '0;
            last_grant  <= SEL_W'(NUM_CH - 1);
        end else if (load_en) begin
            if (has_pick) begin
                bus.valid_o <= 1'b1;
                bus.data_o  <= ch_data[pick];
                bus.grant_o <= pick;
                last_grant  <= pick;
            end else begin
                bus.valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: select mode (4 and 3 channels) and round-robin mode.
module tb_stream_mux;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    stream_mux_if #(.WIDTH(8), .NUM_CH(4)) if0 ();
    stream_mux_if #(.WIDTH(8), .NUM_CH(4)) if1 ();
    stream_mux_if #(.WIDTH(8), .NUM_CH(3)) if2 ();

    stream_mux #(.WIDTH(8), .NUM_CH(4), .MODE(0)) u_sel (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
    stream_mux #(.WIDTH(8), .NUM_CH(4), .MODE(1)) u_rr  (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
    stream_mux #(.WIDTH(8), .NUM_CH(3), .MODE(0)) u_sel3(.clk(clk), .reset_n(reset_n), .bus(if2.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int exp_all [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_alt [4] = '{1, 3, 1, 3};

    initial begin
        if0.data_i = {8'h13, 8'h12, 8'h11, 8'h10};
        if1.data_i = {8'h13, 8'h12, 8'h11, 8'h10};
        if2.data_i = {8'h12, 8'h11, 8'h10};
        if0.valid_i = 4'b1111; if1.valid_i = 4'b1111; if2.valid_i = 3'b111;
        if0.ready_i = 1'b1;    if1.ready_i = 1'b1;    if2.ready_i = 1'b1;
        if0.sel_i = 2'd0;      if1.sel_i = 2'd3;      if2.sel_i = 2'd3;

        // Reset held with every channel valid
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid0", 32'(if0.valid_o), 0);
        chk("rst_data0",  32'(if0.data_o), 0);
        chk("rst_grant0", 32'(if0.grant_o), 0);
        chk("rst_ready0", 32'(if0.ready_o), 0);
        chk("rst_valid1", 32'(if1.valid_o), 0);
        chk("rst_ready1", 32'(if1.ready_o), 0);
        chk("rst_ready2", 32'(if2.ready_o), 0);

        // Release: first load is ch0 in both modes; 3-ch sel=3 chooses nothing
        reset_n = 1'b1;
        #1;
        chk("rel_ready0", 32'(if0.ready_o), 32'b0001);
        chk("rel_ready1", 32'(if1.ready_o), 32'b0001);
        chk("oor_ready",  32'(if2.ready_o), 0);
        step;
        chk("first_data0",  32'(if0.data_o), 32'h10);
        chk("first_grant0", 32'(if0.grant_o), 0);
        chk("first_valid0", 32'(if0.valid_o), 1);
        chk("first_data1",  32'(if1.data_o), 32'h10);
        chk("first_grant1", 32'(if1.grant_o), 0);
        chk("oor_valid",    32'(if2.valid_o), 0);

        // Select ch2; round-robin instance is stalled from here
        if1.ready_i = 1'b0;
        if0.sel_i = 2'd2;
        if2.sel_i = 2'd2;
        #1;
        chk("sel2_ready",  32'(if0.ready_o), 32'b0100);
        chk("sel2_ready3", 32'(if2.ready_o), 32'b100);
        chk("stall_ready1", 32'(if1.ready_o), 0);
        step;
        chk("sel2_data",   32'(if0.data_o), 32'h12);
        chk("sel2_grant",  32'(if0.grant_o), 2);
        chk("sel2_data3",  32'(if2.data_o), 32'h12);
        chk("sel2_valid3", 32'(if2.valid_o), 1);

        // Back-pressure: sel change while stalled must not disturb the held word
        if0.ready_i = 1'b0;
        if0.sel_i = 2'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(if0.ready_o), 0);
            step;
            chk("bp_data",  32'(if0.data_o), 32'h12);
            chk("bp_grant", 32'(if0.grant_o), 2);
            chk("bp_valid", 32'(if0.valid_o), 1);
        end
        if0.ready_i = 1'b1;
        #1;
        chk("drain_ready", 32'(if0.ready_o), 32'b1000);
        step;
        chk("drain_data",  32'(if0.data_o), 32'h13);
        chk("drain_grant", 32'(if0.grant_o), 3);
        chk("drain_valid", 32'(if0.valid_o), 1);

        // Reset mid-stream while round-robin output is stalled
        chk("hold_valid1", 32'(if1.valid_o), 1);
        chk("hold_data1",  32'(if1.data_o), 32'h10);
        reset_n = 1'b0;
        #1;
        chk("arst_valid1", 32'(if1.valid_o), 0);
        chk("arst_data1",  32'(if1.data_o), 0);
        step;
        if1.ready_i = 1'b1;
        reset_n = 1'b1;
        #1;
        chk("arst_ptr", 32'(if1.ready_o), 32'b0001);

        // All channels active: grants rotate with no bubbles
        for (int i = 0; i < 8; i++) begin
            chk("rr_ready", 32'(if1.ready_o), 32'(1) << exp_all[i]);
            step;
            chk("rr_grant", 32'(if1.grant_o), 32'(exp_all[i]));
            chk("rr_data",  32'(if1.data_o), 32'(8'h10 + exp_all[i]));
            chk("rr_valid", 32'(if1.valid_o), 1);
        end

        // Two active channels alternate
        if1.valid_i = 4'b1010;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("alt_ready", 32'(if1.ready_o), 32'(1) << exp_alt[i]);
            step;
            chk("alt_grant", 32'(if1.grant_o), 32'(exp_alt[i]));
        end

        // Single active channel granted every cycle
        if1.valid_i = 4'b0010;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("one_ready", 32'(if1.ready_o), 32'b0010);
            step;
            chk("one_grant", 32'(if1.grant_o), 1);
            chk("one_valid", 32'(if1.valid_o), 1);
        end

        // Inputs go idle: valid_o falls one clk after the last handshake
        if1.valid_i = 4'b0000;
        #1;
        chk("idle_ready", 32'(if1.ready_o), 0);
        step;
        chk("idle_valid", 32'(if1.valid_o), 0);
        chk("idle_grant", 32'(if1.grant_o), 1);
        chk("idle_data",  32'(if1.data_o), 32'h11);
        step;

        // Pointer did not move while idle: search resumes after ch1
        if1.valid_i = 4'b1111;
        #1;
        chk("resume_ready", 32'(if1.ready_o), 32'b0100);
        step;
        chk("resume_grant", 32'(if1.grant_o), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
